// File: rtl/bcd_to_binary_seq_if.sv
// Handshake bundle for the sequential BCD-to-binary converter.
// The switch-side logic is the master and the converter is the slave.
interface bcd_to_binary_seq_if #(
    parameter int DIGITS    = 3,
    parameter int BIN_WIDTH = 10
);
    logic [4*DIGITS-1:0]  bcd_in;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [BIN_WIDTH-1:0] binary_out;
    logic                 error;

    modport master (output bcd_in, start, input  busy, done, binary_out, error);
    modport slave  (input  bcd_in, start, output busy, done, binary_out, error);
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Reverse double-dabble BCD-to-binary converter, one bit per clock.
// Optional digit/overflow checking is enabled by defining BCD2BIN_ERROR_CHECK_EN.
module bcd_to_binary_seq #(
    parameter int DIGITS    = 3,
    parameter int BIN_WIDTH = 10
) (
    input  logic               clock,
    input  logic               reset_n,
    bcd_to_binary_seq_if.slave bus
);
    localparam int BCD_W = 4*DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH+1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state, state_nx;
    logic [BCD_W-1:0]     bcd_reg, bcd_nx;
    logic [BIN_WIDTH-1:0] bin_reg, bin_nx;
    logic [CNT_W-1:0]     cnt;
    logic [BIN_WIDTH-1:0] bin_out_q;
    logic                 done_q;
    logic                 load, step, finish, digit_bad;

`ifdef BCD2BIN_ERROR_CHECK_EN
    logic err_q;

    always_comb begin
        digit_bad = 1'b0;
        for (int d = 0; d < DIGITS; d++)
            if (bus.bcd_in[4*d +: 4] > 4'd9) digit_bad = 1'b1;
    end
`else
    assign digit_bad = 1'b0;
`endif

    // One step: shift right, then pull every digit that came in >=8 back by 3.
    always_comb begin
        {bcd_nx, bin_nx} = {1'b0, bcd_reg, bin_reg[BIN_WIDTH-1:1]};
        for (int d = 0; d < DIGITS; d++)
            if (bcd_nx[4*d +: 4] >= 4'd8) bcd_nx[4*d +: 4] = bcd_nx[4*d +: 4] - 4'd3;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                load     = 1'b1;
                state_nx = digit_bad ? DONE : SHIFT;
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == CNT_W'(1)) state_nx = DONE;
            end
            DONE: begin
                finish   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A bad operand skips SHIFT: bin_reg stays 0 and the nonzero bcd_reg
    // makes the residual check in DONE raise error on its own.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bcd_reg   <= '0;
            bin_reg   <= '0;
            cnt       <= '0;
            bin_out_q <= '0;
            done_q    <= 1'b0;
`ifdef BCD2BIN_ERROR_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            done_q <= finish;
            if (load) begin
                bcd_reg <= bus.bcd_in;
                bin_reg <= '0;
                cnt     <= CNT_W'(BIN_WIDTH);
`ifdef BCD2BIN_ERROR_CHECK_EN
                err_q   <= 1'b0;
`endif
            end else if (step) begin
                bcd_reg <= bcd_nx;
                bin_reg <= bin_nx;
                cnt     <= cnt - 1'b1;
            end
            if (finish) begin
                bin_out_q <= bin_reg;
`ifdef BCD2BIN_ERROR_CHECK_EN
                err_q     <= |bcd_reg;
`endif
            end
        end
    end

    assign bus.busy       = (state != IDLE);
    assign bus.done       = done_q;
    assign bus.binary_out = bin_out_q;
`ifdef BCD2BIN_ERROR_CHECK_EN
    assign bus.error      = err_q;
`else
    assign bus.error      = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed bench for bcd_to_binary_seq: default 10-bit build plus an 8-bit instance
// for the truncation case; error expectations follow BCD2BIN_ERROR_CHECK_EN.
module tb_bcd_to_binary_seq;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    bcd_to_binary_seq_if #(.DIGITS(3), .BIN_WIDTH(10)) bus ();
    bcd_to_binary_seq_if #(.DIGITS(3), .BIN_WIDTH(8))  bus8 ();

    bcd_to_binary_seq #(.DIGITS(3), .BIN_WIDTH(10)) dut  (.clock(clock), .reset_n(reset_n), .bus(bus));
    bcd_to_binary_seq #(.DIGITS(3), .BIN_WIDTH(8))  dut8 (.clock(clock), .reset_n(reset_n), .bus(bus8));

    always #5 clock = ~clock;

`ifdef BCD2BIN_ERROR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    // Runs one conversion on the 10-bit DUT; lat = edges from accept to done, -1 on timeout.
    task automatic convert(input logic [11:0] v, output int lat, output int busy_n,
                           output logic [9:0] res, output logic err);
        lat = -1; busy_n = 0; res = '0; err = 1'b0;
        @(negedge clock); bus.bcd_in = v; bus.start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock); bus.start = 1'b0;
            if (bus.busy) busy_n++;
            if (bus.done) begin lat = n - 1; res = bus.binary_out; err = bus.error; break; end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; bus.start = 1'b0; bus.bcd_in = '0; bus8.start = 1'b0; bus8.bcd_in = '0;
        repeat (3) @(negedge clock);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_cmp++; if (bus.binary_out !== 10'd0) begin n_bad++; $display("FAIL reset_bin got %0d want 0", bus.binary_out); end
        n_cmp++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", bus.error); end
        n_cmp++; if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin n_bad++; $display("FAIL reset_dut8 got done=%b busy=%b want 0 0", bus8.done, bus8.busy); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_values;
        logic [11:0] vin [6] = '{12'h255, 12'h000, 12'h001, 12'h128, 12'h999, 12'h512};
        int          exp [6] = '{255, 0, 1, 128, 999, 512};
        int lat, bn; logic [9:0] res; logic err;
        for (int i = 0; i < 6; i++) begin
            convert(vin[i], lat, bn, res, err);
            n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL lat_%h got %0d want 11", vin[i], lat); end
            n_cmp++; if (res !== exp[i][9:0]) begin n_bad++; $display("FAIL val_%h got %0d want %0d", vin[i], res, exp[i]); end
            n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_%h got %b want 0", vin[i], err); end
            if (i == 0) begin
                n_cmp++; if (bn !== 11) begin n_bad++; $display("FAIL busy_len got %0d want 11", bn); end
                @(negedge clock);
                n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL done_pulse got %b want 0", bus.done); end
            end
        end
    endtask

    task automatic test_invalid;
        int lat, bn; logic [9:0] res; logic err;
        convert(12'h1A3, lat, bn, res, err);
        if (CHK) begin
            n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL inv_lat got %0d want 1", lat); end
            n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL inv_err got %b want 1", err); end
            n_cmp++; if (res !== 10'd0) begin n_bad++; $display("FAIL inv_val got %0d want 0", res); end
        end else begin
            n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL inv_lat got %0d want 11", lat); end
            n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL inv_err got %b want 0", err); end
        end
        // the next good conversion must clear error
        convert(12'h042, lat, bn, res, err);
        n_cmp++; if (err !== 1'b0 || res !== 10'd42) begin n_bad++; $display("FAIL post_inv got val=%0d err=%b want 42 0", res, err); end
    endtask

    task automatic test_back_to_back;
        int t [2] = '{-1, -1};
        logic [9:0] v [2] = '{10'd0, 10'd0};
        int nd = 0;
        @(negedge clock); bus.bcd_in = 12'h999; bus.start = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clock);
            if (n == 1) bus.bcd_in = 12'h000;
            if (bus.done) begin
                if (nd < 2) begin t[nd] = n - 1; v[nd] = bus.binary_out; end
                nd++;
                if (nd == 2) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        n_cmp++; if (nd !== 2) begin n_bad++; $display("FAIL b2b_count got %0d want 2", nd); end
        n_cmp++; if (t[0] !== 11) begin n_bad++; $display("FAIL b2b_lat got %0d want 11", t[0]); end
        n_cmp++; if (t[1] - t[0] !== 12) begin n_bad++; $display("FAIL b2b_spacing got %0d want 12", t[1] - t[0]); end
        n_cmp++; if (v[0] !== 10'd999) begin n_bad++; $display("FAIL b2b_val0 got %0d want 999", v[0]); end
        n_cmp++; if (v[1] !== 10'd0) begin n_bad++; $display("FAIL b2b_val1 got %0d want 0", v[1]); end
    endtask

    task automatic test_ignored_start;
        int nd = 0, lat = -1;
        logic [9:0] res = '0;
        @(negedge clock); bus.bcd_in = 12'h042; bus.start = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clock);
            if (n == 1) begin bus.start = 1'b0; bus.bcd_in = 12'h777; end
            if (n == 5) bus.start = 1'b1;
            if (n == 6) bus.start = 1'b0;
            if (bus.done) begin nd++; if (nd == 1) begin lat = n - 1; res = bus.binary_out; end end
        end
        n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL ign_count got %0d want 1", nd); end
        n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL ign_lat got %0d want 11", lat); end
        n_cmp++; if (res !== 10'd42) begin n_bad++; $display("FAIL ign_val got %0d want 42", res); end
    endtask

    task automatic test_reset_mid;
        int nd = 0, lat, bn; logic [9:0] res; logic err;
        @(negedge clock); bus.bcd_in = 12'h123; bus.start = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clock); bus.start = 1'b0;
            if (bus.done) nd++;
        end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.binary_out !== 10'd0) begin n_bad++; $display("FAIL rst_mid_bin got %0d want 0", bus.binary_out); end
        n_cmp++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL rst_mid_err got %b want 0", bus.error); end
        repeat (3) begin @(negedge clock); if (bus.done) nd++; end
        reset_n = 1'b1;
        repeat (12) begin @(negedge clock); if (bus.done) nd++; end
        n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL rst_mid_done got %0d want 0", nd); end
        convert(12'h007, lat, bn, res, err);
        n_cmp++; if (res !== 10'd7 || lat !== 11) begin n_bad++; $display("FAIL rst_mid_after got val=%0d lat=%0d want 7 11", res, lat); end
    endtask

    task automatic test_width8;
        int lat = -1;
        logic [7:0] res = '0;
        logic err = 1'b0;
        @(negedge clock); bus8.bcd_in = 12'h300; bus8.start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock); bus8.start = 1'b0;
            if (bus8.done) begin lat = n - 1; res = bus8.binary_out; err = bus8.error; break; end
        end
        n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL w8_lat got %0d want 9", lat); end
        n_cmp++; if (res !== 8'd44) begin n_bad++; $display("FAIL w8_val got %0d want 44", res); end
        n_cmp++; if (err !== CHK) begin n_bad++; $display("FAIL w8_err got %b want %b", err, CHK); end
    endtask

    initial begin
        bus.start = 1'b0; bus.bcd_in = '0; bus8.start = 1'b0; bus8.bcd_in = '0;
        test_reset;
        test_values;
        test_invalid;
        test_back_to_back;
        test_ignored_start;
        test_reset_mid;
        test_width8;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
